// File: rtl/axis_flow_generator.sv
// Multi-flow AXI4-Stream Ethernet frame source: round-robin flows, optional 802.1Q tag,
// inter-frame gap and done/busy status. Define GEN_STATS_EN to build the frame/stall counters.
module axis_flow_generator #(
  parameter int          AXIS_DATA_WIDTH  = 256,
  parameter int          AXIS_TUSER_WIDTH = 128,
  parameter int          NUM_FLOWS        = 4,
  parameter logic [47:0] SRC_MAC_BASE     = 48'h0000_0000_0001,
  parameter logic [47:0] DST_MAC_BASE     = 48'h0000_0000_1998,
  parameter int          DST_STEP         = 0,
  parameter int          VLAN             = 0,
  parameter logic [2:0]  PCP              = 3'd0,
  parameter logic [11:0] VID              = 12'd1,
  parameter int          FRAME_BYTES      = 64,
  parameter int          SRC_PORT         = 0,
  parameter int          WAIT_CYCLES      = 400,
  parameter int          GAP_CYCLES       = 0,
  parameter int          SEND_NUMS        = 100
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic                          enable,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   frames_sent,
  output logic [31:0]                   stall_cycles
);

  localparam int BPB   = AXIS_DATA_WIDTH / 8;
  localparam int BEATS = (FRAME_BYTES * 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int REM   = FRAME_BYTES % BPB;

  localparam logic [31:0]    ETH_OFF      = (VLAN != 0) ? 32'd16 : 32'd12;
  localparam logic [31:0]    SEQ_OFF      = ETH_OFF + 32'd2;
  localparam logic [31:0]    FLOW_OFF     = SEQ_OFF + 32'd4;
  localparam logic [31:0]    FRAME_LEN    = 32'(FRAME_BYTES);
  localparam logic [BPB-1:0] FULL_KEEP    = '1;
  localparam logic [BPB-1:0] LAST_KEEP    = (REM == 0) ? FULL_KEEP : (FULL_KEEP >> (BPB - REM));
  localparam logic [15:0]    LAST_BEAT    = 16'(BEATS - 1);
  localparam logic [3:0]     LAST_FLOW    = 4'(NUM_FLOWS - 1);
  localparam logic [31:0]    WAIT_LEN     = 32'(WAIT_CYCLES);
  localparam logic [31:0]    GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]    TOTAL_FRAMES = 32'(NUM_FLOWS * SEND_NUMS);
  localparam logic [31:0]    VLAN_TAG     = {16'h8100, PCP, 1'b0, VID};
  localparam logic [15:0]    ETHERTYPE    = 16'h88B5;
  localparam logic [7:0]     SRC_ONEHOT   = 8'(1 << SRC_PORT);
  localparam logic [AXIS_TUSER_WIDTH-1:0] TUSER_VAL =
    AXIS_TUSER_WIDTH'({SRC_ONEHOT, 16'(FRAME_BYTES)});

  typedef enum logic [2:0] {ST_WAIT, ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 waitCnt_q, waitCnt_d;
  logic [31:0]                 gapCnt_q, gapCnt_d;
  logic [15:0]                 beat_q, beat_d;
  logic [3:0]                  flow_q, flow_d;
  logic [31:0]                 seq_q, seq_d;
  logic [31:0]                 total_q, total_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [BPB-1:0]              tkeep_q, tkeep_d;
  logic [AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                        load;
  logic [15:0]                 loadBeat;
  logic [3:0]                  loadFlow;
  logic [31:0]                 loadSeq;
  logic                        hs;

  function automatic logic [7:0] frameByte(input logic [31:0] off, input logic [3:0] flow,
                                           input logic [31:0] seq);
    logic [47:0] dst;
    logic [47:0] src;
    logic [7:0]  b;
    dst = DST_MAC_BASE + ((DST_STEP != 0) ? {44'd0, flow} : 48'd0);
    src = SRC_MAC_BASE + {44'd0, flow};
    if (off < 32'd6)                       b = dst[8*(32'd5 - off) +: 8];
    else if (off < 32'd12)                 b = src[8*(32'd11 - off) +: 8];
    else if ((VLAN != 0) && off < 32'd16)  b = VLAN_TAG[8*(32'd15 - off) +: 8];
    else if (off < ETH_OFF + 32'd2)        b = ETHERTYPE[8*(ETH_OFF + 32'd1 - off) +: 8];
    else if (off < SEQ_OFF + 32'd4)        b = seq[8*(SEQ_OFF + 32'd3 - off) +: 8];
    else if (off == FLOW_OFF)              b = {4'd0, flow};
    else                                   b = off[7:0];
    return b;
  endfunction

  // Bytes past the end of the frame stay zero so the partial last beat is clean.
  function automatic logic [AXIS_DATA_WIDTH-1:0] beatData(input logic [15:0] beat,
                                                          input logic [3:0] flow,
                                                          input logic [31:0] seq);
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [31:0]                off;
    data = '0;
    for (int i = 0; i < BPB; i++) begin
      off = 32'(beat) * 32'(BPB) + 32'(i);
      if (off < FRAME_LEN) data[8*i +: 8] = frameByte(off, flow, seq);
    end
    return data;
  endfunction

  assign hs = tvalid_q & m_axis_tready;

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    gapCnt_d  = gapCnt_q;
    beat_d    = beat_q;
    flow_d    = flow_q;
    seq_d     = seq_q;
    total_d   = total_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tuser_d   = tuser_q;
    load      = 1'b0;
    loadBeat  = 16'd0;
    loadFlow  = flow_q;
    loadSeq   = seq_q;
    unique case (state_q)
      ST_WAIT: begin
        if (waitCnt_q + 32'd1 >= WAIT_LEN) state_d = ST_IDLE;
        else                               waitCnt_d = waitCnt_q + 32'd1;
      end
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SEND;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs && !tlast_q) begin
          load     = 1'b1;
          loadBeat = beat_q + 16'd1;
        end else if (hs) begin
          flow_d   = (flow_q == LAST_FLOW) ? 4'd0 : flow_q + 4'd1;
          seq_d    = seq_q + 32'd1;
          total_d  = total_q + 32'd1;
          beat_d   = 16'd0;
          tvalid_d = 1'b0;
          // With no gap, the next frame's first beat is loaded on the same edge.
          if ((SEND_NUMS != 0) && (total_q + 32'd1 == TOTAL_FRAMES)) begin
            state_d = ST_DONE;
          end else if (GAP_CYCLES != 0) begin
            state_d  = ST_GAP;
            gapCnt_d = 32'd0;
          end else if (enable) begin
            load     = 1'b1;
            loadFlow = flow_d;
            loadSeq  = seq_d;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          if (enable) begin
            state_d = ST_SEND;
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gapCnt_d = gapCnt_q + 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_WAIT;
    endcase
    if (load) begin
      tvalid_d = 1'b1;
      beat_d   = loadBeat;
      tdata_d  = beatData(loadBeat, loadFlow, loadSeq);
      tkeep_d  = (loadBeat == LAST_BEAT) ? LAST_KEEP : FULL_KEEP;
      tlast_d  = (loadBeat == LAST_BEAT);
      tuser_d  = TUSER_VAL;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= ST_WAIT;
      waitCnt_q <= '0;
      gapCnt_q  <= '0;
      beat_q    <= '0;
      flow_q    <= '0;
      seq_q     <= '0;
      total_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tuser_q   <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      gapCnt_q  <= gapCnt_d;
      beat_q    <= beat_d;
      flow_q    <= flow_d;
      seq_q     <= seq_d;
      total_q   <= total_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tuser_q   <= tuser_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done          = (state_q == ST_DONE);

`ifdef GEN_STATS_EN
  logic [31:0] framesSent_q;
  logic [31:0] stallCycles_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      framesSent_q  <= '0;
      stallCycles_q <= '0;
    end else begin
      if (hs && tlast_q && (framesSent_q != 32'hFFFF_FFFF)) framesSent_q <= framesSent_q + 32'd1;
      if (tvalid_q && !m_axis_tready && (stallCycles_q != 32'hFFFF_FFFF))
        stallCycles_q <= stallCycles_q + 32'd1;
    end
  end

  assign frames_sent  = framesSent_q;
  assign stall_cycles = stallCycles_q;
`else
  assign frames_sent  = 32'd0;
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_axis_flow_generator.sv
// Bench for axis_flow_generator: 3 flows, 65-byte VLAN frames, gap of 3, 4 frames per flow.
module tb_axis_flow_generator;

  localparam int DW     = 256;
  localparam int TUW    = 128;
  localparam int NF     = 3;
  localparam int FB     = 65;
  localparam int WAITC  = 10;
  localparam int GAPC   = 3;
  localparam int SENDN  = 4;
  localparam int TOTAL  = NF * SENDN;
  localparam int BEATS  = 3;
  localparam logic [TUW-1:0] EXP_TUSER = 128'h0004_0041;

  logic           clock = 1'b0;
  logic           rstn;
  logic           enable;
  logic           tready;
  logic [DW-1:0]  tdata;
  logic [31:0]    tkeep;
  logic [TUW-1:0] tuser;
  logic           tvalid;
  logic           tlast;
  logic           busy;
  logic           done;
  logic [31:0]    framesSent;
  logic [31:0]    stallCycles;

  int vectors = 0;
  int miscompares = 0;

  axis_flow_generator #(
    .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(TUW), .NUM_FLOWS(NF),
    .SRC_MAC_BASE(48'h0000_0000_0001), .DST_MAC_BASE(48'h0000_0000_1998), .DST_STEP(1),
    .VLAN(1), .PCP(3'd0), .VID(12'd5), .FRAME_BYTES(FB), .SRC_PORT(2),
    .WAIT_CYCLES(WAITC), .GAP_CYCLES(GAPC), .SEND_NUMS(SENDN)
  ) dut (
    .axis_aclk(clock), .axis_resetn(rstn), .enable(enable),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .busy(busy), .done(done), .frames_sent(framesSent), .stall_cycles(stallCycles)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference frame: a 23-byte header followed by bytes equal to their own offset.
  function automatic logic [7:0] expByte(input int frame, input int off);
    logic [47:0]  dst;
    logic [47:0]  src;
    logic [183:0] hdr;
    dst = 48'h1998 + 48'(frame % NF);
    src = 48'h0001 + 48'(frame % NF);
    hdr = {dst, src, 16'h8100, 16'h0005, 16'h88B5, 32'(frame), 8'(frame % NF)};
    if (off < 23) return hdr[(22 - off) * 8 +: 8];
    return 8'(off);
  endfunction

  function automatic logic [DW-1:0] expData(input int frame, input int beat);
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < 32; j++)
      if (beat * 32 + j < FB) d[j*8 +: 8] = expByte(frame, beat * 32 + j);
    return d;
  endfunction

  function automatic logic [31:0] expKeep(input int beat);
    int n;
    n = FB - beat * 32;
    if (n >= 32) return 32'hFFFF_FFFF;
    return 32'((64'd1 << n) - 64'd1);
  endfunction

  int            mFrames, mBeat, lowRun;
  bit            prevValid, prevStall, prevHsLast, enHeld, capEn;
  logic [DW-1:0] prevData;
  logic [31:0]   prevKeep;
  logic          prevLast;
  logic [DW-1:0] capData [0:1][0:2];
  logic [31:0]   capKeep [0:1][0:2];

  // Compare process: sampled on the falling edge, model indexed by frame and beat.
  always @(negedge clock) begin
    if (!rstn) begin
      mFrames = 0; mBeat = 0; lowRun = 0;
      prevValid = 0; prevStall = 0; prevHsLast = 0; enHeld = 1;
    end else begin
      checkOutput("done", 256'(done), 256'(mFrames == TOTAL));
      if (prevHsLast) checkOutput("gap_start_tvalid", 256'(tvalid), 256'd0);
      if (mBeat != 0) checkOutput("tvalid_midframe", 256'(tvalid), 256'd1);
      if (tvalid) begin
        if (!prevValid && mFrames > 0 && enHeld)
          checkOutput("gap_len", 256'(lowRun), 256'(GAPC));
        if (prevStall) begin
          checkOutput("hold_tdata", tdata, prevData);
          checkOutput("hold_tkeep", 256'(tkeep), 256'(prevKeep));
          checkOutput("hold_tlast", 256'(tlast), 256'(prevLast));
        end
        checkOutput("tdata", tdata, expData(mFrames, mBeat));
        checkOutput("tkeep", 256'(tkeep), 256'(expKeep(mBeat)));
        checkOutput("tlast", 256'(tlast), 256'(mBeat == BEATS - 1));
        checkOutput("tuser", 256'(tuser), 256'(EXP_TUSER));
        checkOutput("busy_sending", 256'(busy), 256'd1);
        if (capEn && mFrames < 2 && tready) begin
          capData[mFrames][mBeat] = tdata;
          capKeep[mFrames][mBeat] = tkeep;
        end
      end
      if (tvalid) lowRun = 0; else lowRun++;
      if (!tvalid && !enable) enHeld = 0;
      prevStall  = tvalid && !tready;
      prevValid  = tvalid;
      prevData   = tdata;
      prevKeep   = tkeep;
      prevLast   = tlast;
      prevHsLast = 0;
      if (tvalid && tready) begin
        if (mBeat == BEATS - 1) begin
          mBeat = 0; mFrames++; prevHsLast = 1; enHeld = 1;
        end else begin
          mBeat++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic rdy);
    @(posedge clock); #1;
    enable = en;
    tready = rdy;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitFrames(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (mFrames < target && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput(name, 256'(mFrames >= target), 256'd1);
  endtask

  // Releases reset on a falling edge and counts rising edges until tvalid appears.
  task automatic releaseAndMeasure(input string name);
    int cnt;
    @(negedge clock);
    rstn = 1'b1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!tvalid && cnt < 200);
    checkOutput(name, 256'(cnt), 256'(WAITC + 1));
  endtask

  initial begin
    int n;
    int framesBefore;
    rstn = 1'b0; enable = 1'b1; tready = 1'b1; capEn = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_tvalid", 256'(tvalid), 256'd0);
    checkOutput("reset_tlast", 256'(tlast), 256'd0);
    checkOutput("reset_tdata", tdata, 256'd0);
    checkOutput("reset_tkeep", 256'(tkeep), 256'd0);
    checkOutput("reset_tuser", 256'(tuser), 256'd0);
    checkOutput("reset_busy", 256'(busy), 256'd0);
    checkOutput("reset_done", 256'(done), 256'd0);

    releaseAndMeasure("first_valid_latency");
    waitFrames("first_two_frames", 2, 100);
    capEn = 1'b0;
    checkOutput("f0_dst_tail", 256'(capData[0][0][4*8 +: 16]), 256'h9819);
    checkOutput("f0_src_lsb", 256'(capData[0][0][11*8 +: 8]), 256'h01);
    checkOutput("f0_vlan_tag", 256'(capData[0][0][12*8 +: 32]), 256'h0500_0081);
    checkOutput("f0_ethertype", 256'(capData[0][0][16*8 +: 16]), 256'hB588);
    checkOutput("f0_payload23", 256'(capData[0][0][23*8 +: 8]), 256'h17);
    checkOutput("f0_beat1_keep", 256'(capKeep[0][1]), 256'hFFFF_FFFF);
    checkOutput("f0_last_keep", 256'(capKeep[0][2]), 256'h1);
    checkOutput("f0_last_data", capData[0][2], 256'h40);
    checkOutput("f1_dst_lsb", 256'(capData[1][0][5*8 +: 8]), 256'h99);
    checkOutput("f1_src_lsb", 256'(capData[1][0][11*8 +: 8]), 256'h02);
    checkOutput("f1_seq_lsb", 256'(capData[1][0][21*8 +: 8]), 256'h01);
    checkOutput("f1_flow", 256'(capData[1][0][22*8 +: 8]), 256'h01);

    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, 1'b1);

    n = 0;
    while (tvalid && n < 50) begin @(posedge clock); #1; n++; end
    while (!tvalid && n < 100) begin @(posedge clock); #1; n++; end
    checkOutput("frame_start_found", 256'(tvalid), 256'd1);
    framesBefore = mFrames;
    applyStimulus(1'b0, 1'b1);
    waitCycles(30);
    checkOutput("en_low_frame_completed", 256'(mFrames), 256'(framesBefore + 1));
    checkOutput("en_low_no_new_frame", 256'(tvalid), 256'd0);
    checkOutput("en_low_busy", 256'(busy), 256'd0);
    applyStimulus(1'b1, 1'b1);

    n = 0;
    while (!done && n < 500) begin @(posedge clock); #1; n++; end
    checkOutput("done_reached", 256'(done), 256'd1);
    checkOutput("done_frames", 256'(mFrames), 256'(TOTAL));
    checkOutput("done_busy", 256'(busy), 256'd0);
    checkOutput("stats_frames_tied", 256'(framesSent), 256'd0);
    checkOutput("stats_stall_tied", 256'(stallCycles), 256'd0);
    waitCycles(20);
    checkOutput("done_sticky", 256'(done), 256'd1);
    checkOutput("done_no_valid", 256'(tvalid), 256'd0);

    rstn = 1'b0;
    #1;
    checkOutput("reset_clears_done", 256'(done), 256'd0);
    waitCycles(2);
    releaseAndMeasure("relaunch_latency");
    @(posedge clock); #1;
    rstn = 1'b0;
    #1;
    checkOutput("midframe_reset_tvalid", 256'(tvalid), 256'd0);
    checkOutput("midframe_reset_tdata", tdata, 256'd0);
    waitCycles(2);
    releaseAndMeasure("post_reset_latency");
    waitFrames("post_reset_frames", 2, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_flow_generator.md
# axis_flow_generator

Synthesizable multi-flow AXI4-Stream Ethernet frame source for datapath self-learning, forwarding and scheduling benches. It generalises the single-flow self-learn packet generator in the following ways:
- N round-robin flows with per-flow MAC stepping.
- Configurable frame length with partial last-beat tkeep.
- Optional 802.1Q tag.
- Inter-frame gap, level enable, and a done/busy status.

It drives one datapath slave port (s_axis_N of datapath_v3) in simulation or on hardware loopback tests.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 256, tdata width; multiple of 64.
- AXIS_TUSER_WIDTH, 128, tuser width.
- NUM_FLOWS, 4, flows interleaved round-robin; 1..16.
- SRC_MAC_BASE, 48'h0000_0000_0001, source MAC of flow 0; flow k uses base+k mod 2^48.
- DST_MAC_BASE, 48'h0000_0000_1998, destination MAC of flow 0.
- DST_STEP, 0, destination MAC increment per flow (0 or 1).
- VLAN, 0, 1 inserts the 802.1Q tag 0x8100 with TCI {PCP,1'b0,VID}.
- PCP, 3'd0, VLAN priority.
- VID, 12'd1, VLAN ID.
- FRAME_BYTES, 64, frame length in bytes excluding FCS; 64..1518.
- SRC_PORT, 0, source port index; tuser[23:16] = 8'b1 << SRC_PORT.
- WAIT_CYCLES, 400, idle cycles after reset release before the first frame.
- GAP_CYCLES, 0, idle cycles between frames.
- SEND_NUMS, 100, frames per flow; 0 = unlimited.

Ports:
- axis_aclk in 1 — clock.
- axis_resetn in 1 — asynchronous active-low reset.
- enable in 1 — level; frames start only while high.
- m_axis_tdata out AXIS_DATA_WIDTH — frame data; byte 0 at [7:0].
- m_axis_tkeep out AXIS_DATA_WIDTH/8 — byte enables.
- m_axis_tuser out AXIS_TUSER_WIDTH — [15:0] = FRAME_BYTES, [23:16] = source port one-hot, remaining bits 0.
- m_axis_tvalid out 1 — beat valid.
- m_axis_tready in 1 — sink ready.
- m_axis_tlast out 1 — last beat of frame.
- busy out 1 — high in SEND or GAP.
- done out 1 — all NUM_FLOWS*SEND_NUMS frames sent; sticky until reset.
- frames_sent out 32 — total completed frames; present only with the statistics macro.
- stall_cycles out 32 — cycles with tvalid & !tready; present only with the statistics macro.

## Operation
- Frame layout, by byte offset:
  - 0-5: dst MAC, MSB first.
  - 6-11: src MAC.
  - If VLAN: 12-15 = 0x8100 followed by TCI.
  - Next 2 bytes: ethertype 0x88B5.
  - Next 4 bytes: global sequence number, big-endian.
  - Next 1 byte: flow index.
  - All remaining bytes: byte offset[7:0].
- Beats per frame = ceil(FRAME_BYTES*8/AXIS_DATA_WIDTH). On the last beat, tkeep has its low (FRAME_BYTES mod bytes-per-beat) bits set; all ones if that remainder is 0. All other beats have tkeep all ones. Bytes not enabled by tkeep are 0.
- FSM states: WAIT, IDLE, SEND, GAP, DONE.
  - WAIT → IDLE when the wait counter reaches WAIT_CYCLES.
  - IDLE → SEND when enable=1.
  - SEND → GAP on the tlast handshake. Goes to DONE instead if the count is now exhausted.
  - GAP → SEND after GAP_CYCLES, if enable=1. If enable=0, GAP → IDLE.
  - GAP_CYCLES=0 with enable=1: SEND directly to SEND; back-to-back frames with no tvalid bubble.
- Flow pointer advances 0,1,…,NUM_FLOWS-1,0 after each frame. The sequence number increments after each frame and wraps at 2^32.
- enable falling mid-frame does not truncate the frame; the frame completes.
- SEND_NUMS=0: DONE is never reached.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0, busy=0, done=0, counters 0, flow pointer 0. Reset takes effect asynchronously, including mid-frame; that frame is discarded, not resumed.
- First tvalid is asserted WAIT_CYCLES+1 cycles after axis_resetn rises, provided enable is held high.
- AXI-Stream rules:
  - tdata, tkeep, tuser and tlast are registered.
  - Once tvalid is high, outputs hold stable until tready.
  - tvalid never drops mid-frame.
- A beat advances on tvalid&tready only.
- Gap counting starts the cycle after the tlast handshake. tvalid is 0 for exactly GAP_CYCLES cycles.
- done rises the cycle after the final tlast handshake.

## Configuration
- GEN_STATS_EN defined: the frames_sent and stall_cycles counters are implemented. Both saturate at 2^32-1 and reset to 0.
- GEN_STATS_EN undefined: no counters are implemented; frames_sent and stall_cycles are tied to 0.

## Test plan
- Defaults with tready=1: 400 frames alternating src MAC …0001,…0002,…0003,…0004. Each frame is 2 beats; the second beat has tkeep=32'hFFFF_FFFF. done is asserted after the 400th tlast.
- FRAME_BYTES=65, VLAN=1, VID=5: 3 beats; the last beat has tkeep=32'h1. Bytes 12-15 = 81 00 00 05 and bytes 16-17 = 88 B5.
- Random tready at 50%: tdata and tlast are held stable during stalls. With GEN_STATS_EN, stall_cycles equals the counted tvalid&!tready cycles.
- GAP_CYCLES=3: exactly 3 tvalid-low cycles between consecutive frames. GAP_CYCLES=0: no tvalid bubble between frames.
- enable deasserted on beat 1 of a frame: the frame completes, no new frame starts. On re-enable, the next frame carries the next flow and sequence number.
- axis_resetn pulsed mid-frame: tvalid drops immediately; after WAIT_CYCLES, the next frame is flow 0 with sequence number 0.
